mem_copy_engine: RTL and testbench
==================================

# mem_copy_engine

Memory-side initiator that drives the data memory's port set: write_en, read_en, base_address, offset_address and data_in, and samples data_out. It executes byte-block COPY or FILL commands issued by the control path. It sequences reads and writes through base+offset displacement addressing, so the CPU need not step a byte loop. It sits between the control unit and the data memory, and owns the memory port while busy.

## Interface
- ADDR_W, 8, address and length width (memory depth is 2^ADDR_W)
- DATA_W, 8, byte width
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- start  in  1  command strobe; sampled only in IDLE
- mode  in  1  0 = COPY, 1 = FILL
- src_base  in  ADDR_W  source base (COPY only)
- dst_base  in  ADDR_W  destination base
- len  in  ADDR_W  byte count, 0..255; 0 is a no-op
- fill_value  in  DATA_W  byte written in FILL mode
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- mem_write_en  out  1  to the memory's write_en
- mem_read_en  out  1  to the memory's read_en
- mem_base_address  out  ADDR_W  to the memory's base_address
- mem_offset_address  out  ADDR_W  to the memory's offset_address
- mem_data_in  out  DATA_W  to the memory's data_in
- mem_data_out  in  DATA_W  from the memory's data_out; combinational read, Z when not reading

## Operation
- **States:** IDLE, RD, WR, FILL, DONE.
- **Command latch:** on start in IDLE, latch src, dst, len, mode and fill_value.
- **Start transitions:**
  - len == 0: go to DONE.
  - COPY with len != 0: go to RD.
  - FILL with len != 0: go to FILL.
- **Start outside IDLE:** ignored; not queued.
- **Direction:** computed once at start.
  - Descending when COPY and src < dst < src+len, using a 9-bit unsigned sum. Index starts at len-1 and counts down to 0.
  - Otherwise ascending: index starts at 0 and counts up to len-1.
- **RD:** mem_read_en=1, base=src, offset=idx. Capture mem_data_out into the hold register at the edge. Go to WR.
- **WR:** mem_write_en=1, base=dst, offset=idx, data_in=hold.
  - Last index: go to DONE.
  - Otherwise: step idx and go to RD.
- **FILL:** mem_write_en=1, base=dst, offset=idx, data_in=fill_value. Step idx each cycle; go to DONE after the last index.
- **DONE:** done=1 for one cycle, then IDLE.
- **Address arithmetic:** the memory forms base+offset modulo 2^ADDR_W, so blocks wrap past the top address. The engine does no wrap detection beyond the overlap test.
- **Mutual exclusion:** mem_read_en and mem_write_en are never high in the same cycle.
- **Idle outputs:** when neither enable is high, address and data outputs are 0.
- **busy:** high in RD, WR and FILL; low in IDLE and DONE.
- **Reset values:** state=IDLE, busy=0, done=0, both enables=0, all address and data outputs 0, idx=0, hold=0.
- **Reset mid-command:** enables drop asynchronously and the command is abandoned. Bytes already written remain; no done pulse is issued.

## Timing
- Start accepted at edge T0. The first memory cycle is T0+1.
- COPY of N bytes: 2N busy cycles (RD/WR alternating), then done in cycle T0+2N+1.
- FILL of N bytes: N busy cycles, then done in cycle T0+N+1.
- len == 0: done in cycle T0+1, with no memory enables asserted.
- Next accept: earliest start accepted at the edge ending the cycle after done, i.e. back in IDLE.
- Read data: mem_data_out is sampled at the end of the RD cycle itself, with no extra wait state. The memory read is combinational.
- Write data: the write commits at the edge ending the WR or FILL cycle.

## Structure
- **Shared package mem_pkg:**
  - state enum `mce_state_t` {IDLE, RD, WR, FILL, DONE}
  - mode enum `mce_mode_t` {MODE_COPY, MODE_FILL}
  - `ADDR_W` and `DATA_W` constants, shared with the data memory
- **Sub-module mce_idx_counter:**
  - loadable up/down 8-bit counter
  - load value and direction inputs
  - step enable
  - `last` flag, high when idx == 0 (down) or idx == len-1 (up)
- **Top level:** FSM, command latch, hold register and output muxing.

## Test plan
- **Ascending COPY:** memory[0x10..0x13] = 11,22,33,44; COPY src=0x10 dst=0x40 len=4.
  - memory[0x40..0x43] = 11,22,33,44.
  - busy for 8 cycles, done at T0+9.
  - Offsets seen 0,0,1,1,2,2,3,3.
- **Overlapping COPY:** src=0x10, dst=0x11, len=3 over bytes A,B,C.
  - Descending offsets 2,2,1,1,0,0.
  - Result: memory[0x11..0x13] = A,B,C with memory[0x10] = A unchanged.
- **FILL with wrap:** dst=0xFE, len=5, fill_value=0xA5.
  - Writes land at 0xFE, 0xFF, 0x00, 0x01, 0x02.
  - done at T0+6; mem_read_en never asserted.
- **len=0:** any mode.
  - done at T0+1, busy never high, no enables.
- **Reset mid-COPY:** COPY len=4, assert reset asynchronously during the third busy cycle.
  - Enables and busy fall before the next edge.
  - Only the destination byte at offset 0 was written; no done pulse.
- **Start while busy:** pulse start with new arguments during an active FILL.
  - The pulse is ignored and the original FILL completes unchanged.
  - A start issued after done is accepted normally.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the data memory and the memory copy engine.
//   ADDR_W / DATA_W  address and byte widths shared with the data memory
//   mce_state_t      copy engine FSM states
//   mce_mode_t       command mode (COPY or FILL)
//   mce_is_descending  overlap test deciding the copy direction
package mem_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        FILL = 3'd3,
        DONE = 3'd4
    } mce_state_t;

    typedef enum logic {
        MODE_COPY = 1'b0,
        MODE_FILL = 1'b1
    } mce_mode_t;

    // A forward copy would overwrite source bytes before reading them when the
    // destination starts inside the source block, so copy from the top down.
    // The sum is one bit wider so src+len past the top address is not lost.
    function automatic logic mce_is_descending(input mce_mode_t          mode,
                                               input logic [ADDR_W-1:0]  src,
                                               input logic [ADDR_W-1:0]  dst,
                                               input logic [ADDR_W-1:0]  len);
        logic [ADDR_W:0] src_end;
        src_end = {1'b0, src} + {1'b0, len};
        return (mode == MODE_COPY) && (src < dst) && ({1'b0, dst} < src_end);
    endfunction

endpackage

// File: rtl/mce_idx_counter.sv
// mce_idx_counter: loadable up/down byte index for the memory copy engine.
//   clk, reset   clock and asynchronous active-high reset
//   load_i       load load_val_i into the index (takes priority over step)
//   load_val_i   starting index
//   down_i       1 = count down, 0 = count up
//   step_i       advance the index by one
//   len_i        block length, used for the ascending last-index test
//   idx_o        current index
//   last_o       index is the final one of the block
module mce_idx_counter
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              down_i,
    input  logic              step_i,
    input  logic [ADDR_W-1:0] len_i,
    output logic [ADDR_W-1:0] idx_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] idx_q, idx_d;

    always_comb begin
        idx_d = idx_q;
        if (load_i) begin
            idx_d = load_val_i;
        end else if (step_i) begin
            idx_d = down_i ? (idx_q - ADDR_W'(1)) : (idx_q + ADDR_W'(1));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o  = idx_q;
    assign last_o = down_i ? (idx_q == '0) : (idx_q == (len_i - ADDR_W'(1)));

endmodule

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: block COPY / FILL initiator driving the data memory port.
//   clk, reset          clock and asynchronous active-high reset
//   start, mode         command strobe (taken in IDLE only), 0 = COPY, 1 = FILL
//   src_base, dst_base  source (COPY only) and destination base addresses
//   len                 byte count, 0 is a no-op
//   fill_value          byte written by FILL
//   busy, done          command in progress / one-cycle completion pulse
//   mem_*               memory port: enables, base+offset address, write data,
//                       and the combinational read data mem_data_out
module mem_copy_engine
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W-1:0] len,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
    output logic              mem_write_en,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] mem_base_address,
    output logic [ADDR_W-1:0] mem_offset_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    mce_state_t        state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] len_q, len_d;
    mce_mode_t         mode_q, mode_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              desc_q, desc_d;

    logic              cmd_load;
    logic              idx_step;
    logic [ADDR_W-1:0] idx_start;
    logic [ADDR_W-1:0] idx;
    logic              idx_last;

    assign desc_d    = mce_is_descending(mce_mode_t'(mode), src_base, dst_base, len);
    assign idx_start = desc_d ? (len - ADDR_W'(1)) : '0;

    mce_idx_counter u_idx (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cmd_load),
        .load_val_i (idx_start),
        .down_i     (desc_q),
        .step_i     (idx_step),
        .len_i      (len_q),
        .idx_o      (idx),
        .last_o     (idx_last)
    );

    // Command latch: the inputs are only looked at on the accepting edge.
    always_comb begin
        src_d  = src_q;
        dst_d  = dst_q;
        len_d  = len_q;
        mode_d = mode_q;
        fill_d = fill_q;
        if (cmd_load) begin
            src_d  = src_base;
            dst_d  = dst_base;
            len_d  = len;
            mode_d = mce_mode_t'(mode);
            fill_d = fill_value;
        end
    end

    always_comb begin
        state_d            = state_q;
        hold_d             = hold_q;
        cmd_load           = 1'b0;
        idx_step           = 1'b0;
        busy               = 1'b0;
        done               = 1'b0;
        mem_read_en        = 1'b0;
        mem_write_en       = 1'b0;
        mem_base_address   = '0;
        mem_offset_address = '0;
        mem_data_in        = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cmd_load = 1'b1;
                    if (len == '0) begin
                        state_d = DONE;
                    end else if (mce_mode_t'(mode) == MODE_FILL) begin
                        state_d = FILL;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                busy               = 1'b1;
                mem_read_en        = 1'b1;
                mem_base_address   = src_q;
                mem_offset_address = idx;
                // Read is combinational, so the byte is valid within this cycle.
                hold_d             = mem_data_out;
                state_d            = WR;
            end
            WR: begin
                busy               = 1'b1;
                mem_write_en       = 1'b1;
                mem_base_address   = dst_q;
                mem_offset_address = idx;
                mem_data_in        = hold_q;
                if (idx_last) begin
                    state_d = DONE;
                end else begin
                    idx_step = 1'b1;
                    state_d  = RD;
                end
            end
            FILL: begin
                busy               = 1'b1;
                mem_write_en       = 1'b1;
                mem_base_address   = dst_q;
                mem_offset_address = idx;
                mem_data_in        = fill_q;
                if (idx_last) begin
                    state_d = DONE;
                end else begin
                    idx_step = 1'b1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            mode_q  <= MODE_COPY;
            fill_q  <= '0;
            hold_q  <= '0;
            desc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            fill_q  <= fill_d;
            hold_q  <= hold_d;
            if (cmd_load) begin
                desc_q <= desc_d;
            end
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
module tb_mem_copy_engine;
    import mem_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       mode;
    logic [7:0] src_base, dst_base, len, fill_value;
    logic       busy, done, mem_write_en, mem_read_en;
    logic [7:0] mem_base_address, mem_offset_address, mem_data_in;
    wire  [7:0] mem_data_out;

    always #5 clk = ~clk;

    mem_copy_engine dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .mode               (mode),
        .src_base           (src_base),
        .dst_base           (dst_base),
        .len                (len),
        .fill_value         (fill_value),
        .busy               (busy),
        .done               (done),
        .mem_write_en       (mem_write_en),
        .mem_read_en        (mem_read_en),
        .mem_base_address   (mem_base_address),
        .mem_offset_address (mem_offset_address),
        .mem_data_in        (mem_data_in),
        .mem_data_out       (mem_data_out)
    );

    // Data memory model: base+offset modulo 256, combinational read.
    logic [7:0] mem [256];
    logic       ld_en = 1'b0;
    logic [7:0] ld_addr = 8'd0, ld_data = 8'd0;
    wire  [7:0] mem_addr = mem_base_address + mem_offset_address;

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (mem_write_en) mem[mem_addr] <= mem_data_in;
    end
    assign mem_data_out = mem_read_en ? mem[mem_addr] : 8'hzz;

    logic [7:0] ref_mem [256];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        ref_mem[a] = d;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    task automatic mem_compare(input string tag);
        int diffs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
        chk(tag, diffs, 0);
    endtask

    // Issues one command and checks the whole transaction against a model
    // built from the command rules: expected memory operations in order,
    // busy/done timing, idle outputs and the final memory image.
    // inject > 0 pulses start with other arguments in that busy cycle.
    task automatic run_cmd(input logic m, input logic [7:0] s, input logic [7:0] d,
                           input logic [7:0] l, input logic [7:0] f, input int inject);
        logic [31:0] exp_ev[$];
        logic [31:0] obs_ev[$];
        bit          desc;
        int          nbusy, done_at, n;
        bit          got_done;
        logic [7:0]  idx, sa, da, wdata;

        desc = (m == 1'b0) && (int'(s) < int'(d)) && (int'(d) < int'(s) + int'(l));
        for (int k = 0; k < int'(l); k++) begin
            idx = desc ? 8'(int'(l) - 1 - k) : 8'(k);
            sa  = s + idx;
            da  = d + idx;
            wdata = m ? f : ref_mem[sa];
            if (!m) exp_ev.push_back({8'd1, s, idx, 8'd0});
            exp_ev.push_back({8'd2, d, idx, wdata});
            ref_mem[da] = wdata;
        end
        nbusy   = m ? int'(l) : 2 * int'(l);
        done_at = nbusy + 1;

        @(negedge clk);
        mode = m; src_base = s; dst_base = d; len = l; fill_value = f; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        got_done = 1'b0;
        for (int c = 1; c <= done_at + 4; c++) begin
            @(negedge clk);
            if (inject > 0 && c == inject) begin
                start = 1'b1; mode = 1'b0; src_base = ~s; dst_base = ~d;
                len = 8'd7; fill_value = ~f;
            end else begin
                start = 1'b0;
            end
            chk("rd_wr_excl", {31'd0, mem_read_en & mem_write_en}, 32'd0);
            if (mem_read_en)
                obs_ev.push_back({8'd1, mem_base_address, mem_offset_address, 8'd0});
            else if (mem_write_en)
                obs_ev.push_back({8'd2, mem_base_address, mem_offset_address, mem_data_in});
            else
                chk("idle_outputs", {8'd0, mem_base_address, mem_offset_address, mem_data_in}, 32'd0);
            chk("busy", {31'd0, busy}, {31'd0, c <= nbusy});
            if (done) begin
                chk("done_cycle", c, done_at);
                got_done = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!got_done) chk("done_timeout", 32'd0, 32'd1);
        chk("op_count", obs_ev.size(), exp_ev.size());
        n = (obs_ev.size() < exp_ev.size()) ? obs_ev.size() : exp_ev.size();
        for (int i = 0; i < n; i++) chk("mem_op", obs_ev[i], exp_ev[i]);
        mem_compare("mem_image");
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] s, d, l;
        logic       m;
        logic [7:0] exp_bytes [4];

        reset = 1'b1; start = 1'b0; mode = 1'b0;
        src_base = 8'd0; dst_base = 8'd0; len = 8'd0; fill_value = 8'd0;
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_enables", {30'd0, mem_read_en, mem_write_en}, 32'd0);
        chk("rst_outputs", {8'd0, mem_base_address, mem_offset_address, mem_data_in}, 32'd0);
        for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
        @(negedge clk);
        reset = 1'b0;

        // Ascending COPY
        poke(8'h10, 8'h11); poke(8'h11, 8'h22); poke(8'h12, 8'h33); poke(8'h13, 8'h44);
        run_cmd(1'b0, 8'h10, 8'h40, 8'd4, 8'h00, 0);
        exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) chk("asc_copy_byte", mem[8'h40 + i], exp_bytes[i]);

        // Overlapping COPY, must run descending
        poke(8'h10, 8'hA1); poke(8'h11, 8'hB2); poke(8'h12, 8'hC3);
        run_cmd(1'b0, 8'h10, 8'h11, 8'd3, 8'h00, 0);
        exp_bytes = '{8'hA1, 8'hA1, 8'hB2, 8'hC3};
        for (int i = 0; i < 4; i++) chk("ovl_copy_byte", mem[8'h10 + i], exp_bytes[i]);

        // FILL wrapping past the top address
        run_cmd(1'b1, 8'h00, 8'hFE, 8'd5, 8'hA5, 0);
        chk("fill_wrap_FE", mem[8'hFE], 8'hA5);
        chk("fill_wrap_02", mem[8'h02], 8'hA5);

        // len == 0 in both modes
        run_cmd(1'b0, 8'h20, 8'h30, 8'd0, 8'h00, 0);
        run_cmd(1'b1, 8'h20, 8'h30, 8'd0, 8'h5A, 0);

        // Start while busy is ignored, then a following start is accepted
        run_cmd(1'b1, 8'h00, 8'h80, 8'd6, 8'h3C, 2);
        run_cmd(1'b0, 8'h80, 8'hC0, 8'd3, 8'h00, 0);

        // Reset in the third busy cycle of a COPY
        @(negedge clk);
        mode = 1'b0; src_base = 8'h60; dst_base = 8'h90; len = 8'd4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy_before_rst", {31'd0, busy}, 32'd1);
        chk("mid_rd_before_rst", {31'd0, mem_read_en}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_enables", {30'd0, mem_read_en, mem_write_en}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        ref_mem[8'h90] = ref_mem[8'h60];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_no_done", {31'd0, done}, 32'd0);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_no_done", {30'd0, done, busy}, 32'd0);
        end
        mem_compare("mid_rst_mem");

        // Randomized commands, biased toward overlaps and short blocks
        for (int t = 0; t < 40; t++) begin
            m = 1'($urandom_range(0, 1));
            s = 8'($urandom);
            d = ($urandom_range(0, 3) == 0) ? 8'(s + 8'($urandom_range(1, 8))) : 8'($urandom);
            l = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 20));
            run_cmd(m, s, d, l, 8'($urandom), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
